// File: rtl/multiplier_datapath.sv
// Multiplier datapath: six-entry register file (R0..R5) plus a combinational
// ALU. The control FSM steers it through read/write selects and closes the
// loop on the status flags. Read addresses 6/7 expose the operand ports.
module multiplier_datapath #(
    parameter int DATAWIDTH     = 16,
    parameter int SELECTIONALU  = 3,
    parameter int SELECTIONDECO = 3
) (
    input  logic                     clk,
    input  logic                     lowRst,
    input  logic [SELECTIONDECO-1:0] sSelDecoA,
    input  logic [SELECTIONDECO-1:0] sSelDecoB,
    input  logic [SELECTIONDECO-1:0] sSelDecoC,
    input  logic [SELECTIONALU-1:0]  sSelAlu,
    input  logic [DATAWIDTH-1:0]     iDataP0,
    input  logic [DATAWIDTH-1:0]     iDataP1,
    output logic [DATAWIDTH-1:0]     oResult,
    output logic                     sOverflow,
    output logic                     sCarry,
    output logic                     sNegative,
    output logic                     sZero,
    output logic                     sPar
);

    localparam int NUM_REGS = 6;

    localparam logic [SELECTIONALU-1:0] ALU_PASS_A = SELECTIONALU'(0);
    localparam logic [SELECTIONALU-1:0] ALU_PASS_B = SELECTIONALU'(1);
    localparam logic [SELECTIONALU-1:0] ALU_ADD    = SELECTIONALU'(2);
    localparam logic [SELECTIONALU-1:0] ALU_SHR    = SELECTIONALU'(3);
    localparam logic [SELECTIONALU-1:0] ALU_SHL    = SELECTIONALU'(4);
    localparam logic [SELECTIONALU-1:0] ALU_SUB    = SELECTIONALU'(5);
    localparam logic [SELECTIONALU-1:0] ALU_AND    = SELECTIONALU'(6);
    localparam logic [SELECTIONALU-1:0] ALU_OR     = SELECTIONALU'(7);

    localparam logic [SELECTIONDECO-1:0] ADDR_P0 = SELECTIONDECO'(6);
    localparam logic [SELECTIONDECO-1:0] ADDR_P1 = SELECTIONDECO'(7);

    logic [DATAWIDTH-1:0] r_regs [NUM_REGS];

    logic [DATAWIDTH-1:0] w_bus_a;
    logic [DATAWIDTH-1:0] w_bus_b;
    logic [DATAWIDTH:0]   w_sum;
    logic [DATAWIDTH:0]   w_diff;
    logic [DATAWIDTH-1:0] w_result;
    logic                 w_carry;
    logic                 w_overflow;

    // Read-port decode: R0..R5 from the register file, 6/7 straight from the
    // operand ports. Out-of-range register codes cannot occur with a 3-bit
    // address, but the default keeps the mux fully specified.
    function automatic logic [DATAWIDTH-1:0] read_bus(
        input logic [SELECTIONDECO-1:0] sel
    );
        logic [DATAWIDTH-1:0] val;
        val = '0;
        if (sel == ADDR_P0) begin
            val = iDataP0;
        end else if (sel == ADDR_P1) begin
            val = iDataP1;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (sel == SELECTIONDECO'(i)) begin
                    val = r_regs[i];
                end
            end
        end
        return val;
    endfunction

    // Combinational bus A / bus B read.
    always_comb begin
        w_bus_a = read_bus(sSelDecoA);
        w_bus_b = read_bus(sSelDecoB);
    end

    // Extended-width add/sub: the extra MSB is the carry-out for add and the
    // borrow (A < B unsigned) for sub.
    always_comb begin
        w_sum  = {1'b0, w_bus_a} + {1'b0, w_bus_b};
        w_diff = {1'b0, w_bus_a} - {1'b0, w_bus_b};
    end

    // ALU operation select, carry and signed-overflow generation.
    always_comb begin
        w_result   = w_bus_a;
        w_carry    = 1'b0;
        w_overflow = 1'b0;
        case (sSelAlu)
            ALU_PASS_A: w_result = w_bus_a;
            ALU_PASS_B: w_result = w_bus_b;
            ALU_ADD: begin
                w_result   = w_sum[DATAWIDTH-1:0];
                w_carry    = w_sum[DATAWIDTH];
                w_overflow = (w_bus_a[DATAWIDTH-1] == w_bus_b[DATAWIDTH-1]) &&
                             (w_sum[DATAWIDTH-1] != w_bus_a[DATAWIDTH-1]);
            end
            ALU_SHR: begin
                w_result = {1'b0, w_bus_a[DATAWIDTH-1:1]};
                w_carry  = w_bus_a[0];
            end
            ALU_SHL: begin
                w_result = {w_bus_a[DATAWIDTH-2:0], 1'b0};
                w_carry  = w_bus_a[DATAWIDTH-1];
            end
            ALU_SUB: begin
                w_result   = w_diff[DATAWIDTH-1:0];
                w_carry    = w_diff[DATAWIDTH];
                w_overflow = (w_bus_a[DATAWIDTH-1] != w_bus_b[DATAWIDTH-1]) &&
                             (w_diff[DATAWIDTH-1] != w_bus_a[DATAWIDTH-1]);
            end
            ALU_AND: w_result = w_bus_a & w_bus_b;
            ALU_OR:  w_result = w_bus_a | w_bus_b;
            default: w_result = w_bus_a;
        endcase
    end

    // Status flags from the current-cycle ALU result, so the FSM can branch
    // in the same cycle it presents the read address.
    always_comb begin
        sZero     = (w_result == '0);
        sPar      = ~w_result[0];
        sNegative = w_result[DATAWIDTH-1];
        sCarry    = w_carry;
        sOverflow = w_overflow;
    end

    // Register-file write: one register per edge, codes 6/7 write nothing.
    // No read bypass, so a same-cycle read of the target sees the old value.
    always_ff @(posedge clk or negedge lowRst) begin
        if (!lowRst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (sSelDecoC == SELECTIONDECO'(i)) begin
                    r_regs[i] <= w_result;
                end
            end
        end
    end

    assign oResult = r_regs[0];

endmodule

// File: tb/tb_multiplier_datapath.sv
// Directed bench for multiplier_datapath: register loads, ALU ops and flags,
// write suppression, same-register read/write, async reset and full
// shift-add multiplies sequenced from the bench.
module tb_multiplier_datapath;

    logic        clk;
    logic        lowRst;
    logic [2:0]  sSelDecoA, sSelDecoB, sSelDecoC;
    logic [2:0]  sSelAlu;
    logic [15:0] iDataP0, iDataP1;
    logic [15:0] oResult;
    logic        sOverflow, sCarry, sNegative, sZero, sPar;

    int n_tests = 0;
    int n_fail  = 0;

    multiplier_datapath #(
        .DATAWIDTH(16), .SELECTIONALU(3), .SELECTIONDECO(3)
    ) dut (
        .clk(clk), .lowRst(lowRst),
        .sSelDecoA(sSelDecoA), .sSelDecoB(sSelDecoB), .sSelDecoC(sSelDecoC),
        .sSelAlu(sSelAlu), .iDataP0(iDataP0), .iDataP1(iDataP1),
        .oResult(oResult), .sOverflow(sOverflow), .sCarry(sCarry),
        .sNegative(sNegative), .sZero(sZero), .sPar(sPar)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Flags packed as {ovf, carry, neg, zero, par}.
    task automatic chk_flags(input string tag, input logic [4:0] exp);
        chk(tag, {27'd0, sOverflow, sCarry, sNegative, sZero, sPar}, {27'd0, exp});
    endtask

    task automatic drive(input logic [2:0] a, input logic [2:0] b,
                         input logic [2:0] c, input logic [2:0] alu);
        sSelDecoA = a;
        sSelDecoB = b;
        sSelDecoC = c;
        sSelAlu   = alu;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Shift-add multiply: R0 = acc, R1 = multiplier, R2 = shifted multiplicand.
    task automatic multiply(input string tag, input logic [15:0] a, input logic [15:0] b);
        logic        done;
        logic [31:0] full;
        full    = a * b;
        iDataP0 = a;
        iDataP1 = b;
        drive(3'd0, 3'd0, 3'd0, 3'b101); tick();
        drive(3'd7, 3'd0, 3'd1, 3'b000); tick();
        drive(3'd6, 3'd0, 3'd2, 3'b000); tick();
        done = 1'b0;
        for (int it = 0; it < 20 && !done; it++) begin
            drive(3'd1, 3'd0, 3'd7, 3'b000);
            #1;
            if (sZero) begin
                done = 1'b1;
            end else begin
                if (!sPar) begin
                    drive(3'd0, 3'd2, 3'd0, 3'b010); tick();
                end
                drive(3'd2, 3'd0, 3'd2, 3'b100); tick();
                drive(3'd1, 3'd0, 3'd1, 3'b011); tick();
            end
        end
        chk({tag, "_done"}, {31'd0, done}, 32'd1);
        chk({tag, "_result"}, {16'd0, oResult}, {16'd0, full[15:0]});
    endtask

    initial begin
        lowRst  = 1'b0;
        iDataP0 = 16'd0;
        iDataP1 = 16'd0;
        drive(3'd0, 3'd0, 3'd7, 3'b000);
        #3;
        chk("reset_oresult", {16'd0, oResult}, 32'd0);
        chk_flags("reset_flags", 5'b00011);
        #5 lowRst = 1'b1;
        tick();

        // Port load into R2, then copy R2 -> R0 to observe it.
        iDataP0 = 16'd6;
        drive(3'd6, 3'd0, 3'd2, 3'b000); tick();
        drive(3'd2, 3'd0, 3'd0, 3'b000); #1;
        chk_flags("read_r2_flags", 5'b00001);
        tick();
        chk("load_r2", {16'd0, oResult}, 32'd6);

        // Codes 6/7 on the write select must not touch any register.
        iDataP1 = 16'h1234;
        drive(3'd7, 3'd0, 3'd6, 3'b000); tick();
        drive(3'd7, 3'd0, 3'd7, 3'b000); tick();
        chk("no_write_67", {16'd0, oResult}, 32'd6);

        // Add with carry-out and zero result.
        iDataP0 = 16'hFFFF;
        drive(3'd6, 3'd0, 3'd0, 3'b000); tick();
        iDataP0 = 16'h0001;
        drive(3'd6, 3'd0, 3'd2, 3'b000); tick();
        chk("load_r0_ffff", {16'd0, oResult}, 32'h0000FFFF);
        drive(3'd0, 3'd2, 3'd7, 3'b010); #1;
        chk_flags("add_carry_flags", 5'b01011);
        drive(3'd0, 3'd2, 3'd0, 3'b010); tick();
        chk("add_wrap_r0", {16'd0, oResult}, 32'd0);

        // Signed overflow on add, borrow and overflow on sub.
        iDataP0 = 16'h7FFF; iDataP1 = 16'h0001;
        drive(3'd6, 3'd7, 3'd7, 3'b010); #1;
        chk_flags("add_ovf_flags", 5'b10101);
        iDataP0 = 16'd3; iDataP1 = 16'd5;
        drive(3'd6, 3'd7, 3'd7, 3'b101); #1;
        chk_flags("sub_borrow_flags", 5'b01101);
        drive(3'd6, 3'd7, 3'd0, 3'b101); tick();
        chk("sub_result", {16'd0, oResult}, 32'h0000FFFE);
        iDataP0 = 16'h8000; iDataP1 = 16'h0001;
        drive(3'd6, 3'd7, 3'd7, 3'b101); #1;
        chk_flags("sub_ovf_flags", 5'b10000);

        // Shifts.
        iDataP0 = 16'd5;
        drive(3'd6, 3'd0, 3'd1, 3'b000); tick();
        drive(3'd1, 3'd0, 3'd7, 3'b011); #1;
        chk_flags("shr_flags", 5'b01001);
        iDataP0 = 16'h8001;
        drive(3'd6, 3'd0, 3'd2, 3'b000); tick();
        drive(3'd2, 3'd0, 3'd7, 3'b100); #1;
        chk_flags("shl_flags", 5'b01001);
        drive(3'd2, 3'd0, 3'd0, 3'b100); tick();
        chk("shl_result", {16'd0, oResult}, 32'd2);

        // Logic ops and pass B.
        iDataP0 = 16'h00F0; iDataP1 = 16'h0F0F;
        drive(3'd6, 3'd7, 3'd7, 3'b110); #1;
        chk_flags("and_flags", 5'b00011);
        drive(3'd6, 3'd7, 3'd7, 3'b111); #1;
        chk_flags("or_flags", 5'b00000);
        drive(3'd6, 3'd7, 3'd0, 3'b111); tick();
        chk("or_result", {16'd0, oResult}, 32'h00000FFF);
        drive(3'd0, 3'd7, 3'd0, 3'b001); tick();
        chk("passb_result", {16'd0, oResult}, 32'h00000F0F);

        // Same-register read/write: the read sees the old value (8 -> 4).
        iDataP0 = 16'd8;
        drive(3'd6, 3'd0, 3'd1, 3'b000); tick();
        drive(3'd1, 3'd0, 3'd1, 3'b011); #1;
        chk_flags("rw_same_flags", 5'b00001);
        tick();
        drive(3'd1, 3'd0, 3'd0, 3'b000); tick();
        chk("rw_same_r1", {16'd0, oResult}, 32'd4);
        drive(3'd2, 3'd0, 3'd0, 3'b000); tick();
        chk("r2_held", {16'd0, oResult}, 32'h00008001);

        // Asynchronous reset between edges, with a write pending.
        drive(3'd2, 3'd0, 3'd3, 3'b000);
        #2 lowRst = 1'b0;
        #1;
        chk("async_reset_oresult", {16'd0, oResult}, 32'd0);
        #1 lowRst = 1'b1;
        drive(3'd2, 3'd0, 3'd0, 3'b000); tick();
        chk("reset_cleared_r2", {16'd0, oResult}, 32'd0);
        drive(3'd1, 3'd0, 3'd0, 3'b000); tick();
        chk("reset_cleared_r1", {16'd0, oResult}, 32'd0);

        // Full multiplies.
        multiply("mul_6x5", 16'd6, 16'd5);
        multiply("mul_13x11", 16'd13, 16'd11);
        multiply("mul_wrap", 16'h0100, 16'h0100);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
